// File: rtl/game_flow_controller.sv
// Game flow sequencer: IDLE -> COUNTDOWN -> PLAY -> FINISH, with optional PAUSED state.
// Optional pause support is enabled by defining GAME_FLOW_PAUSE_EN.
module game_flow_controller #(
   parameter int GAME_TICKS      = 60,
   parameter int COUNTDOWN_TICKS = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       tick,
   input  logic       cleared,
   input  logic       pause,
   output logic [2:0] state,
   output logic       play_en,
   output logic       clear_field,
   output logic [6:0] time_left,
   output logic [4:0] digit_tens,
   output logic [4:0] digit_ones,
   output logic       finished,
   output logic       win
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      COUNTDOWN = 3'd1,
      PLAY      = 3'd2,
      FINISH    = 3'd3,
      PAUSED    = 3'd4
   } state_t;

   localparam logic [6:0] TIME_INIT = 7'(GAME_TICKS);
   localparam logic [3:0] CD_INIT   = 4'(COUNTDOWN_TICKS);

   state_t     state_reg;
   logic [3:0] cd_reg;
   logic [6:0] time_left_reg;
   logic       play_en_reg;
   logic       clear_field_reg;
   logic       finished_reg;
   logic       win_reg;
   logic       en_q;
   logic       en_rise;
   logic       pause_rise;

   assign en_rise = en & ~en_q;

`ifdef GAME_FLOW_PAUSE_EN
   logic pause_q;

   // Reset to 1 so a pause held high through reset release does not toggle.
   always_ff @(posedge clk) begin
      if (rst) pause_q <= 1'b1;
      else     pause_q <= pause;
   end

   assign pause_rise = pause & ~pause_q;
`else
   logic pause_unused;
   assign pause_unused = pause;
   assign pause_rise   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         cd_reg          <= 4'd0;
         time_left_reg   <= 7'd0;
         play_en_reg     <= 1'b0;
         clear_field_reg <= 1'b0;
         finished_reg    <= 1'b0;
         win_reg         <= 1'b0;
         en_q            <= 1'b1;
      end else begin
         en_q            <= en;
         clear_field_reg <= 1'b0;
         if (en_rise) begin
            state_reg       <= COUNTDOWN;
            cd_reg          <= CD_INIT;
            time_left_reg   <= TIME_INIT;
            win_reg         <= 1'b0;
            clear_field_reg <= 1'b1;
            play_en_reg     <= 1'b0;
            finished_reg    <= 1'b0;
         end else begin
            case (state_reg)
               COUNTDOWN: begin
                  if (cd_reg == 4'd0) begin
                     state_reg   <= PLAY;
                     play_en_reg <= 1'b1;
                  end else if (tick) begin
                     cd_reg <= cd_reg - 4'd1;
                     if (cd_reg == 4'd1) begin
                        state_reg   <= PLAY;
                        play_en_reg <= 1'b1;
                     end
                  end
               end
               PLAY: begin
                  // Clearing the field beats a coincident tick: the win keeps its time.
                  if (cleared) begin
                     state_reg    <= FINISH;
                     win_reg      <= 1'b1;
                     finished_reg <= 1'b1;
                     play_en_reg  <= 1'b0;
                  end else if (pause_rise) begin
                     state_reg   <= PAUSED;
                     play_en_reg <= 1'b0;
                  end else if (tick) begin
                     if (time_left_reg <= 7'd1) begin
                        time_left_reg <= 7'd0;
                        state_reg     <= FINISH;
                        win_reg       <= 1'b0;
                        finished_reg  <= 1'b1;
                        play_en_reg   <= 1'b0;
                     end else begin
                        time_left_reg <= time_left_reg - 7'd1;
                     end
                  end
               end
               PAUSED: begin
                  if (pause_rise) begin
                     state_reg   <= PLAY;
                     play_en_reg <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      digit_tens = 5'd31;
      digit_ones = 5'd31;
      case (state_reg)
         COUNTDOWN: digit_ones = {1'b0, cd_reg};
         PLAY, PAUSED, FINISH: begin
            digit_tens = 5'(time_left_reg / 7'd10);
            digit_ones = 5'(time_left_reg % 7'd10);
         end
         default: ;
      endcase
   end

   assign state       = state_reg;
   assign play_en     = play_en_reg;
   assign clear_field = clear_field_reg;
   assign time_left   = time_left_reg;
   assign finished    = finished_reg;
   assign win         = win_reg;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed self-checking bench for game_flow_controller (default parameters).
module tb_game_flow_controller;

   logic       clk = 1'b0;
   logic       rst, en, tick, cleared, pause;
   logic [2:0] state;
   logic       play_en, clear_field, finished, win;
   logic [6:0] time_left;
   logic [4:0] digit_tens, digit_ones;

   int check_cnt = 0;
   int pass_cnt  = 0;

   game_flow_controller dut (
      .clk(clk), .rst(rst), .en(en), .tick(tick), .cleared(cleared), .pause(pause),
      .state(state), .play_en(play_en), .clear_field(clear_field), .time_left(time_left),
      .digit_tens(digit_tens), .digit_ones(digit_ones), .finished(finished), .win(win)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      check_cnt++;
      if (obs == exp) begin
         pass_cnt++;
         $display("check %s: got %0d", tag, obs);
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the edge; outputs are sampled there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
      end
   endtask

   task automatic start_game();
      en = 1'b0; step();
      en = 1'b1; step();
      do_ticks(3);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; tick = 1'b0; cleared = 1'b0; pause = 1'b0;
      step(); step();
      rst = 1'b0; step();
      check("rst_state", state, 0);
      check("rst_time", time_left, 0);
      check("rst_play_en", play_en, 0);
      check("rst_finished", finished, 0);
      check("rst_clear", clear_field, 0);
      check("idle_tens", digit_tens, 31);
      check("idle_ones", digit_ones, 31);

      en = 1'b1; step();
      check("cd_state", state, 1);
      check("cd_clear_pulse", clear_field, 1);
      check("cd_time", time_left, 60);
      check("cd_tens", digit_tens, 31);
      check("cd_ones", digit_ones, 3);
      step();
      check("cd_clear_one_cycle", clear_field, 0);
      check("cd_hold_no_tick", state, 1);
      do_ticks(2);
      check("cd_ones_after2", digit_ones, 1);
      check("cd_still", state, 1);
      do_ticks(1);
      check("play_state", state, 2);
      check("play_en", play_en, 1);
      check("play_tens", digit_tens, 6);
      check("play_ones", digit_ones, 0);

      pause = 1'b1; step();
`ifdef GAME_FLOW_PAUSE_EN
      check("pause_enter", state, 4);
      pause = 1'b0;
      step();
      pause = 1'b1; step();
      check("pause_leave", state, 2);
`else
      check("pause_ignored", state, 2);
`endif
      pause = 1'b0;

      do_ticks(18);
      check("time_42", time_left, 42);
      check("tens_42", digit_tens, 4);
      check("ones_42", digit_ones, 2);
      cleared = 1'b1; tick = 1'b1; step();
      cleared = 1'b0; tick = 1'b0;
      check("clr_state", state, 3);
      check("clr_win", win, 1);
      check("clr_time", time_left, 42);
      check("clr_finished", finished, 1);
      check("clr_play_en", play_en, 0);
      do_ticks(1);
      check("finish_hold_time", time_left, 42);

      en = 1'b0; step();
      en = 1'b1; tick = 1'b1; step();
      tick = 1'b0;
      check("restart_state", state, 1);
      check("restart_time", time_left, 60);
      check("restart_win", win, 0);
      check("restart_finished", finished, 0);
      check("restart_cd", digit_ones, 3);
      check("restart_clear", clear_field, 1);

      do_ticks(3);
      check("play2_state", state, 2);
      do_ticks(59);
      check("time_1", time_left, 1);
      check("time_1_state", state, 2);
      do_ticks(1);
      check("tout_state", state, 3);
      check("tout_time", time_left, 0);
      check("tout_finished", finished, 1);
      check("tout_win", win, 0);
      check("tout_tens", digit_tens, 0);
      check("tout_ones", digit_ones, 0);
      do_ticks(3);
      check("tout_hold_time", time_left, 0);
      check("tout_hold_state", state, 3);
      cleared = 1'b1; step(); cleared = 1'b0;
      check("finish_ignore_clr", win, 0);

      start_game();
      do_ticks(1);
      check("mid_time_59", time_left, 59);
      rst = 1'b1; tick = 1'b1; cleared = 1'b1; step();
      tick = 1'b0; cleared = 1'b0;
      check("midrst_state", state, 0);
      check("midrst_time", time_left, 0);
      check("midrst_play_en", play_en, 0);

      en = 1'b1; step();
      rst = 1'b0; step(); step();
      check("en_held_idle", state, 0);
      en = 1'b0; step();
      en = 1'b1; step();
      check("en_rise_cd", state, 1);

`ifdef GAME_FLOW_PAUSE_EN
      do_ticks(3);
      do_ticks(30);
      check("p_time_30", time_left, 30);
      pause = 1'b1; step(); pause = 1'b0;
      check("p_state", state, 4);
      check("p_play_en", play_en, 0);
      do_ticks(5);
      cleared = 1'b1; step(); cleared = 1'b0;
      check("p_hold_time", time_left, 30);
      check("p_hold_state", state, 4);
      pause = 1'b1; step(); pause = 1'b0;
      check("p_resume", state, 2);
      do_ticks(1);
      check("p_time_29", time_left, 29);
`endif

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
